// File: rtl/rv6_amo_pkg.sv
// Shared definitions for the AMO/LR/SC unit: data width, funct5 encodings,
// FSM states, the latched request record and a funct5 legality helper.
package rv6_amo_pkg;

  localparam int XLEN = 64;

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  typedef struct packed {
    logic [4:0]      op;
    logic            w;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rs2;
  } amo_req_t;

  function automatic logic funct5_ok(input logic [4:0] f);
    case (f)
      F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO write-data generator (old memory value op rs2).
// Word mode works on bits [31:0] and zero-fills the upper half.
module amo_alu
  import rv6_amo_pkg::*;
(
  input  logic [4:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] new_val
);

  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] res;

  always_comb begin
    if (w) begin
      lt_s = $signed(old[31:0]) < $signed(rs2[31:0]);
      lt_u = old[31:0] < rs2[31:0];
    end else begin
      lt_s = $signed(old) < $signed(rs2);
      lt_u = old < rs2;
    end

    res = old;
    case (op)
      F5_ADD:  res = old + rs2;
      F5_SWAP: res = rs2;
      F5_XOR:  res = old ^ rs2;
      F5_OR:   res = old | rs2;
      F5_AND:  res = old & rs2;
      F5_MIN:  res = lt_s ? old : rs2;
      F5_MAX:  res = lt_s ? rs2 : old;
      F5_MINU: res = lt_u ? old : rs2;
      F5_MAXU: res = lt_u ? rs2 : old;
      default: res = old;
    endcase

    // Low half of a 64-bit result equals the 32-bit result for every op here.
    new_val = w ? {32'b0, res[31:0]} : res;
  end

endmodule

// File: rtl/amo_unit.sv
// AMO/LR/SC sequencer: read-modify-write over a strobe/ack bus plus LR/SC reservation.
// Zero-wait latency AMO +3, LR/SC-ok +2, fail/fault +1; strobes held until mem_ack.
module amo_unit
  import rv6_amo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            amo_req,
  output logic            amo_ack,
  input  logic [4:0]      amo_funct5,
  input  logic            amo_w,
  input  logic [XLEN-1:0] amo_addr,
  input  logic [XLEN-1:0] amo_rs2,
  output logic [XLEN-1:0] amo_rd,
  output logic            amo_misaligned,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_w,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  input  logic            snoop_wr,
  input  logic [XLEN-1:0] snoop_addr
);

  localparam logic [XLEN-1:0] DW_MASK = ~{{(XLEN-3){1'b0}}, 3'b111};

  state_e          state_q, state_d;
  amo_req_t        req_q;
  logic [XLEN-1:0] wdata_q, rd_q, alu_new;
  logic            mis_q;
  logic            res_vld_q;
  logic [XLEN-1:0] res_addr_q;   // doubleword-aligned reservation address

  logic misaligned, supported, snoop_hit, sc_match, lr_set, lr_snoop;

  assign misaligned = amo_w ? (amo_addr[1:0] != 2'b00) : (amo_addr[2:0] != 3'b000);
  assign supported  = funct5_ok(amo_funct5);
  assign snoop_hit  = snoop_wr && res_vld_q && ((snoop_addr & DW_MASK) == res_addr_q);
  // A snoop landing in the same cycle as the SC sample already kills the reservation.
  assign sc_match   = res_vld_q && ((amo_addr & DW_MASK) == res_addr_q) && !snoop_hit;
  assign lr_set     = (state_q == S_READ) && mem_ack && (req_q.op == F5_LR);
  assign lr_snoop   = snoop_wr && ((snoop_addr & DW_MASK) == (req_q.addr & DW_MASK));

  amo_alu u_alu (
    .op      (req_q.op),
    .w       (req_q.w),
    .old     (mem_rdata),
    .rs2     (req_q.rs2),
    .new_val (alu_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    amo_ack = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (amo_req) begin
          if (misaligned || !supported) state_d = S_DONE;
          else if (amo_funct5 == F5_SC) state_d = sc_match ? S_WRITE : S_DONE;
          else                          state_d = S_READ;
        end
      end
      S_READ: begin
        mem_rd = 1'b1;
        if (mem_ack) state_d = (req_q.op == F5_LR) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        mem_wr = 1'b1;
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        amo_ack = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!amo_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      mis_q      <= 1'b0;
      res_vld_q  <= 1'b0;
      res_addr_q <= '0;
    end else begin
      if (state_q == S_IDLE && amo_req) begin
        req_q   <= '{op: amo_funct5, w: amo_w, addr: amo_addr, rs2: amo_rs2};
        wdata_q <= amo_rs2;
        mis_q   <= misaligned && supported;
        rd_q    <= (amo_funct5 == F5_SC && !misaligned && !sc_match) ? 64'd1 : 64'd0;
      end
      if (state_q == S_READ && mem_ack) begin
        rd_q    <= req_q.w ? {{32{mem_rdata[31]}}, mem_rdata[31:0]} : mem_rdata;
        wdata_q <= alu_new;
      end

      if (lr_set) begin
        res_vld_q  <= !lr_snoop;
        res_addr_q <= req_q.addr & DW_MASK;
      end else if (snoop_hit || (state_q == S_DONE && req_q.op == F5_SC)) begin
        res_vld_q  <= 1'b0;
      end
    end
  end

  assign amo_rd         = rd_q;
  assign amo_misaligned = (state_q == S_DONE) && mis_q;
  assign mem_addr       = req_q.addr;
  assign mem_w          = req_q.w;
  assign mem_wdata      = wdata_q;

endmodule

// File: doc/amo_unit.md
AMO_UNIT -- requirements
Module: amo_unit

Interface
REQ-001 XLEN, 64, data/address width; only 64 is supported.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 amo_req  in  1  hart AMO/LR/SC request; held high by the hart until amo_ack.
REQ-005 amo_ack  out  1  single-cycle completion pulse to the hart.
REQ-006 amo_funct5  in  5  operation: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
REQ-007 amo_w  in  1  1 = word (.W), 0 = doubleword (.D).
REQ-008 amo_addr  in  XLEN  effective address (rs1).
REQ-009 amo_rs2  in  XLEN  source operand (rs2).
REQ-010 amo_rd  out  XLEN  result for rd; valid only while amo_ack is high.
REQ-011 amo_misaligned  out  1  alignment fault; valid only while amo_ack is high.
REQ-012 mem_rd / mem_wr  out  1 each  data-bus read/write strobes; never both high.
REQ-013 mem_addr  out  XLEN  bus address.  mem_w  out  1  word-size access.  mem_wdata  out  XLEN  write data.
REQ-014 mem_rdata  in  XLEN  read data.  mem_ack  in  1  bus transfer complete; may arrive in the same cycle the strobe rises.
REQ-015 snoop_wr  in  1  / snoop_addr  in  XLEN  plain store committed by any hart; used to clear the reservation.

Function
REQ-016 States: IDLE, READ, WRITE, DONE, HOLD.
REQ-017 IDLE with amo_req=1 latches funct5, w, addr and rs2, then transitions as follows:
- misaligned (word: addr[1:0]!=0; double: addr[2:0]!=0) or unsupported funct5 -> DONE.
- SC -> WRITE if the reservation is valid and matches; otherwise -> DONE.
- all other operations -> READ.
REQ-018 READ holds mem_rd=1 with the latched address until mem_ack, then captures mem_rdata.
- LR: sets the reservation and goes to DONE.
- other operations: go to WRITE.
REQ-019 WRITE holds mem_wr=1 with mem_wdata until mem_ack, then goes to DONE.
- AMO: mem_wdata = ALU(old, rs2).
- SC: mem_wdata = rs2.
REQ-020 DONE asserts amo_ack for exactly one cycle, then goes to HOLD. HOLD returns to IDLE in the first cycle amo_req=0; no re-trigger while the request is still high.
REQ-021 ALU, word mode: operates on bits [31:0] only; the MIN/MAX comparisons are 32-bit; mem_wdata[63:32]=0.
REQ-022 ALU, signedness: MIN/MAX compare signed; MINU/MAXU compare unsigned.
REQ-023 amo_rd for AMO and LR is the old memory value, sign-extended from bit 31 in word mode.
REQ-024 amo_rd for SC is 0 on success and 1 on failure. Unsupported or misaligned requests give amo_rd=0; misaligned additionally gives amo_misaligned=1.
REQ-025 Reservation = valid bit + doubleword-granular address (addr[63:3]).
- Match: valid && addr[63:3] equal.
- Cleared by any SC (success or fail), at completion.
- Cleared by snoop_wr with a matching address.
- A snoop in the same cycle LR sets it wins: the reservation ends cleared.
REQ-026 Latency from the cycle amo_req is sampled, with zero-wait mem_ack: AMO ack at +3, LR +2, SC success +2, SC fail/misaligned/unsupported +1.
REQ-027 mem_addr, mem_w and mem_wdata are stable for the whole strobe; strobes drop the cycle after mem_ack.

Reset
REQ-028 rst forces, asynchronously and in any state including mid-transfer:
- state=IDLE; reservation invalid;
- amo_ack=0, mem_rd=0, mem_wr=0, amo_misaligned=0;
- amo_rd=0, mem_addr=0, mem_wdata=0, mem_w=0.
REQ-029 An aborted bus transfer is not resumed after reset release.

Structure
REQ-030 Shared package rv6_amo_pkg holds the funct5 encodings, the state enumeration and XLEN.
REQ-031 One combinational sub-module, amo_alu (op, w, old, rs2 -> new), computes the write data; amo_unit contains the FSM, reservation and registers.

Verification
REQ-032 AMOADD.D, addr 0x1000, mem=5, rs2=7, zero-wait bus -> read 0x1000, write 12, amo_rd=5, ack at +3.
REQ-033 AMOMIN.W, mem=0x0000_0000_FFFF_FFFE, rs2=3 -> writes 0xFFFF_FFFE, amo_rd=0xFFFF_FFFF_FFFF_FFFE; AMOMINU.W with the same values writes 3.
REQ-034 LR.D 0x2000, then SC.D 0x2000 rs2=9 -> write 9, amo_rd=0. Second SC.D 0x2000 -> no bus access, amo_rd=1, ack at +1.
REQ-035 LR.D 0x2000, snoop_wr at 0x2004, then SC.D 0x2000 -> fails (amo_rd=1), mem_wr never asserted.
REQ-036 AMOSWAP.W at 0x3002 -> amo_misaligned=1, amo_rd=0, no strobes, ack at +1.
REQ-037 AMOOR.D with mem_ack delayed 4 cycles, rst pulsed during WRITE -> strobes drop immediately, no amo_ack. After release, a new request completes normally and amo_req held high after ack does not re-trigger.
